// File: rtl/FIR_pkg.sv
// -----------------------------------------------------------------------------
// FIR_pkg
// Shared types and constants for the multi-clock-adder (MCA) sequencer.
//   mca_seq_state_t      : sequencer FSM state encoding
//   MCA_DEFAULT_*        : default parameter values for mca_sequencer
//   mca_default_latency  : adder-tree latency implied by a given fan-in
// -----------------------------------------------------------------------------
package FIR_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } mca_seq_state_t;

    localparam int MCA_DEFAULT_WIDTH          = 32;
    localparam int MCA_DEFAULT_NUM_ADDITIONS  = 16;
    // The adder tree spends two clocks per addition stage.
    localparam int MCA_LATENCY_PER_ADDITION   = 2;
    localparam int MCA_DEFAULT_LATENCY        = MCA_LATENCY_PER_ADDITION * MCA_DEFAULT_NUM_ADDITIONS;
    localparam logic [15:0] MCA_DROP_MAX      = 16'hFFFF;

    function automatic int mca_default_latency(input int num_additions);
        return MCA_LATENCY_PER_ADDITION * num_additions;
    endfunction

endpackage

// File: rtl/mca_sequencer.sv
// -----------------------------------------------------------------------------
// mca_sequencer
// Sequences one computation of a multi-clock adder tree per accepted strobe:
// latches the control matrix, pulses start, waits LATENCY cycles, then
// captures the tree result into a one-deep output buffer with valid/ready.
// Strobes arriving while a computation is in flight are dropped and counted.
//
// Ports
//   clk          in   rising-edge clock
//   resetn       in   asynchronous active-low reset
//   enable       in   allows new computations to be accepted
//   s_strobe     in   pulse: new control-bit vector ready (no backpressure)
//   s_load       out  pulse: datapath latches S_matrix
//   start        out  pulse to the adder tree
//   sample_in    in   adder-tree result (signed, WIDTH_COEFFICIENT)
//   out_data     out  buffered sample
//   out_valid    out  out_data holds an unconsumed sample
//   out_ready    in   consumer accepts out_data when out_valid
//   busy         out  FSM not in IDLE
//   overrun      out  sticky: at least one strobe was dropped
//   overrun_clr  in   synchronous clear of overrun and drop_count
//   drop_count   out  saturating count of dropped strobes
// -----------------------------------------------------------------------------
module mca_sequencer
    import FIR_pkg::*;
#(
    parameter int WIDTH_COEFFICIENT = MCA_DEFAULT_WIDTH,
    parameter int MCA_NUM_ADDITIONS = MCA_DEFAULT_NUM_ADDITIONS,
    parameter int LATENCY           = mca_default_latency(MCA_NUM_ADDITIONS)
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                enable,
    input  logic                                s_strobe,
    output logic                                s_load,
    output logic                                start,
    input  logic signed [WIDTH_COEFFICIENT-1:0] sample_in,
    output logic signed [WIDTH_COEFFICIENT-1:0] out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                busy,
    output logic                                overrun,
    input  logic                                overrun_clr,
    output logic [15:0]                         drop_count
);

    localparam int               CNT_W     = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    mca_seq_state_t   state, state_next;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
    logic             capture;
    logic             drop;

    // The buffer can take a new sample when it is empty or being drained
    // this very cycle.
    assign capture = (state == CAPTURE) && (!out_valid || out_ready);

    // Any strobe outside IDLE is lost, regardless of enable.
    assign drop = s_strobe && (state != IDLE);

    assign busy = (state != IDLE);

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next-state and pulse outputs. The counter is loaded in START with
    // LATENCY-1 and the FSM enters CAPTURE in the cycle the counter reaches
    // zero, which puts CAPTURE exactly LATENCY cycles after the start pulse.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        s_load        = 1'b0;
        start         = 1'b0;
        case (state)
            IDLE: begin
                if (s_strobe && enable) begin
                    state_next = START;
                end
            end
            START: begin
                s_load        = 1'b1;
                start         = 1'b1;
                wait_cnt_next = WAIT_LOAD;
                state_next    = (LATENCY == 1) ? CAPTURE : WAIT;
            end
            WAIT: begin
                wait_cnt_next = wait_cnt - CNT_ONE;
                // <= guards against a stuck zero ever being seen here.
                if (wait_cnt <= CNT_ONE) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (capture) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One-deep output buffer. A capture and a consume in the same cycle keep
    // out_valid high with the new sample; the datapath holds sample_in
    // until the next start, so waiting in CAPTURE loses nothing.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (capture) begin
            out_data  <= sample_in;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Overrun bookkeeping. A clear coincident with a drop is applied first,
    // so the drop still registers as the first event after the clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun    <= 1'b0;
            drop_count <= '0;
        end else if (overrun_clr) begin
            overrun    <= drop;
            drop_count <= {15'd0, drop};
        end else if (drop) begin
            overrun <= 1'b1;
            if (drop_count != MCA_DROP_MAX) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/mca_sequencer.md
MCA_SEQUENCER -- requirements
Module: mca_sequencer

Interface
REQ-001 SHALL have parameter WIDTH_COEFFICIENT, default 32, sample width in bits (max 32).
REQ-002 SHALL have parameter MCA_NUM_ADDITIONS, default 16, adder-tree fan-in per stage.
REQ-003 SHALL have parameter LATENCY, default 2*MCA_NUM_ADDITIONS, cycles from start to valid datapath result (min 1).
REQ-004 SHALL use one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 enable  in  1  allows new computations to be accepted.
REQ-007 s_strobe  in  1  one-cycle pulse: new control-bit vector ready; no backpressure.
REQ-008 s_load  out  1  one-cycle pulse: datapath latches S_matrix.
REQ-009 start  out  1  one-cycle pulse to multi-clock adder tree.
REQ-010 sample_in  in  WIDTH_COEFFICIENT signed  adder-tree result.
REQ-011 out_data  out  WIDTH_COEFFICIENT signed  buffered sample.
REQ-012 out_valid  out  1  out_data holds an unconsumed sample.
REQ-013 out_ready  in  1  consumer accepts out_data when out_valid.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 overrun  out  1  sticky: a strobe was dropped.
REQ-016 overrun_clr  in  1  synchronous clear of overrun and drop_count.
REQ-017 drop_count  out  16  saturating count of dropped strobes.

Function
REQ-018 SHALL implement states IDLE, START, WAIT, CAPTURE.
REQ-019 IDLE: s_strobe=1 and enable=1 in cycle T -> START in T+1; s_strobe with enable=0 is ignored and not counted.
REQ-020 START: s_load=1 and start=1 for exactly this cycle; wait counter loaded with LATENCY-1; next state WAIT (CAPTURE directly if LATENCY=1).
REQ-021 WAIT: counter decrements each cycle; at 0 -> CAPTURE; CAPTURE cycle = start cycle + LATENCY.
REQ-022 CAPTURE: if out_valid=0 or out_ready=1, register sample_in into out_data, set out_valid, -> IDLE; else remain in CAPTURE (sample_in is held by datapath until next start).
REQ-023 out_valid SHALL clear on out_valid&out_ready unless a capture occurs the same cycle, in which case it stays 1 with new data.
REQ-024 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 s_strobe in START, WAIT or CAPTURE SHALL be dropped: overrun set next cycle, drop_count +1, saturating at 16'hFFFF.
REQ-026 overrun_clr coincident with a drop: clear wins, then count becomes 1 and overrun 1 (drop applied after clear).
REQ-027 enable deasserted mid-operation SHALL NOT abort; current sample completes.
REQ-028 Minimum strobe spacing without drop = LATENCY+2 cycles with out_ready held 1.
REQ-029 No arithmetic on sample_in; passes bit-exact.

Reset
REQ-030 resetn low SHALL asynchronously force IDLE, s_load=0, start=0, out_valid=0, out_data=0, busy=0, overrun=0, drop_count=0, wait counter=0.
REQ-031 Reset mid-operation SHALL discard in-flight sample; no start pulse after release until a new strobe.

Structure
REQ-032 State enum typedef mca_seq_state_t and default latency constant SHALL live in FIR_pkg.
REQ-033 Counter width SHALL be $clog2(LATENCY+1).
REQ-034 Single module; no sub-module required.

Verification
REQ-035 Reset, strobe at cycle 10, LATENCY=32, sample_in=32'h0000_1234 -> start at 11, out_valid at 44, out_data=32'h0000_1234.
REQ-036 out_ready=0 with out_valid=1, second strobe completes -> FSM holds CAPTURE, out_data unchanged; out_ready=1 -> new sample loaded same cycle, out_valid stays 1.
REQ-037 Strobes at 10 and 20 (LATENCY=32) -> second dropped, overrun=1, drop_count=1, one start pulse only.
REQ-038 70000 dropped strobes -> drop_count=16'hFFFF; overrun_clr -> 0 next cycle.
REQ-039 resetn low during WAIT -> all outputs reset values immediately; no out_valid after release.
REQ-040 enable=0 strobe in IDLE -> no start, drop_count unchanged; enable=0 during WAIT -> sample still delivered.
